// File: rtl/lsu_req_queue.sv
// Load/store request queue: two-lane in-order push into a circular FIFO, drained one
// request at a time through a registered memory handshake with a one-cycle DONE gap.
module lsu_req_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in0_vld,
  input  logic                         in0_store,
  input  logic [ADDR_W-1:0]            in0_addr,
  input  logic [DATA_W-1:0]            in0_data,
  input  logic [TAG_W-1:0]             in0_tag,
  input  logic                         in1_vld,
  input  logic                         in1_store,
  input  logic [ADDR_W-1:0]            in1_addr,
  input  logic [DATA_W-1:0]            in1_data,
  input  logic [TAG_W-1:0]             in1_tag,
  output logic                         in_ready,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_data,
  output logic                         mem_load,
  output logic                         mem_store,
  input  logic                         mem_done,
  input  logic [DATA_W-1:0]            mem_load_data,
  output logic                         ld_rsp_vld,
  output logic [TAG_W-1:0]             ld_rsp_tag,
  output logic [DATA_W-1:0]            ld_rsp_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [1:0]                   dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Handshake: a lane with vld high is accepted at a rising edge iff in_ready is high
  // at that edge; a valid lane seen while in_ready is low is dropped and sets overflow.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              store;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t           r_mem [DEPTH];
  state_t           r_state;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  entry_t           w_ent0;
  entry_t           w_ent1;
  entry_t           w_wr_a;
  entry_t           w_head_ent;
  logic             w_wr_a_vld;
  logic             w_wr_b_vld;
  logic [1:0]       w_n_push;
  logic             w_drop;
  logic             w_pop;
  logic [PTR_W-1:0] w_tail_p1;

  assign w_ent0     = '{store: in0_store, addr: in0_addr, data: in0_data, tag: in0_tag};
  assign w_ent1     = '{store: in1_store, addr: in1_addr, data: in1_data, tag: in1_tag};
  assign w_head_ent = r_mem[r_head];
  assign w_tail_p1  = r_tail + PTR_W'(1);

  assign in_ready = (r_count <= CNT_W'(DEPTH - 2));

  // A lone lane-1 request still lands at tail so the queue stays dense.
  assign w_wr_a_vld = in_ready && (in0_vld || in1_vld);
  assign w_wr_b_vld = in_ready && in0_vld && in1_vld;
  assign w_wr_a     = in0_vld ? w_ent0 : w_ent1;
  assign w_n_push   = {1'b0, w_wr_a_vld} + {1'b0, w_wr_b_vld};
  assign w_drop     = !in_ready && (in0_vld || in1_vld);
  assign w_pop      = (r_state == BUSY) && mem_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_wr_a_vld) r_mem[r_tail]    <= w_wr_a;
      if (w_wr_b_vld) r_mem[w_tail_p1] <= w_ent1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_load    <= 1'b0;
      mem_store   <= 1'b0;
      ld_rsp_vld  <= 1'b0;
      ld_rsp_tag  <= '0;
      ld_rsp_data <= '0;
    end else begin
      r_tail     <= r_tail + PTR_W'(w_n_push);
      r_count    <= r_count + CNT_W'(w_n_push) - CNT_W'(w_pop);
      r_overflow <= r_overflow | w_drop;
      case (r_state)
        IDLE: begin
          if (r_count != '0) begin
            mem_addr  <= w_head_ent.addr;
            mem_data  <= w_head_ent.data;
            mem_load  <= !w_head_ent.store;
            mem_store <= w_head_ent.store;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          if (mem_done) begin
            mem_load  <= 1'b0;
            mem_store <= 1'b0;
            r_head    <= r_head + PTR_W'(1);
            if (mem_load) begin
              ld_rsp_vld  <= 1'b1;
              ld_rsp_tag  <= w_head_ent.tag;
              ld_rsp_data <= mem_load_data;
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          ld_rsp_vld <= 1'b0;
          if (r_count != '0) begin
            mem_addr  <= w_head_ent.addr;
            mem_data  <= w_head_ent.data;
            mem_load  <= !w_head_ent.store;
            mem_store <= w_head_ent.store;
            r_state   <= BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign count     = r_count;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lsu_req_queue.sv
// Bench for lsu_req_queue: queue-based reference model compared every cycle, plus
// directed sequences with literal expectations and a randomized phase.
module tb_lsu_req_queue;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int DEPTH  = 8;

  typedef struct packed {
    logic              store;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in0_vld = 1'b0, in0_store = 1'b0;
  logic [ADDR_W-1:0] in0_addr = '0;
  logic [DATA_W-1:0] in0_data = '0;
  logic [TAG_W-1:0]  in0_tag = '0;
  logic              in1_vld = 1'b0, in1_store = 1'b0;
  logic [ADDR_W-1:0] in1_addr = '0;
  logic [DATA_W-1:0] in1_data = '0;
  logic [TAG_W-1:0]  in1_tag = '0;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_load, mem_store;
  logic              mem_done = 1'b0;
  logic [DATA_W-1:0] mem_load_data = '0;
  logic              ld_rsp_vld;
  logic [TAG_W-1:0]  ld_rsp_tag;
  logic [DATA_W-1:0] ld_rsp_data;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic              overflow;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  lsu_req_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in0_vld(in0_vld), .in0_store(in0_store), .in0_addr(in0_addr), .in0_data(in0_data), .in0_tag(in0_tag),
    .in1_vld(in1_vld), .in1_store(in1_store), .in1_addr(in1_addr), .in1_data(in1_data), .in1_tag(in1_tag),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_load(mem_load), .mem_store(mem_store),
    .mem_done(mem_done), .mem_load_data(mem_load_data),
    .ld_rsp_vld(ld_rsp_vld), .ld_rsp_tag(ld_rsp_tag), .ld_rsp_data(ld_rsp_data),
    .count(count), .overflow(overflow), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending requests live in mq in arrival order; mq[0] is in flight while m_busy.
  ent_t              mq[$];
  logic              m_busy = 1'b0;
  ent_t              m_cur = '0;
  logic              m_ovf = 1'b0;
  logic              m_rsp_vld = 1'b0;
  logic [TAG_W-1:0]  m_rsp_tag = '0;
  logic [DATA_W-1:0] m_rsp_data = '0;

  always @(posedge clk) begin
    int   pre;
    logic ready;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_busy = 1'b0; m_cur = '0; m_ovf = 1'b0;
      m_rsp_vld = 1'b0; m_rsp_tag = '0; m_rsp_data = '0;
    end else begin
      pre   = mq.size();
      ready = (pre <= DEPTH - 2);
      if (m_busy) begin
        if (mem_done) begin
          e = mq.pop_front();
          m_busy = 1'b0;
          if (!e.store) begin
            m_rsp_vld = 1'b1; m_rsp_tag = e.tag; m_rsp_data = mem_load_data;
          end
        end
      end else begin
        m_rsp_vld = 1'b0;
        if (pre > 0) begin
          m_busy = 1'b1;
          m_cur  = mq[0];
        end
      end
      if (ready) begin
        if (in0_vld) mq.push_back('{store: in0_store, addr: in0_addr, data: in0_data, tag: in0_tag});
        if (in1_vld) mq.push_back('{store: in1_store, addr: in1_addr, data: in1_data, tag: in1_tag});
      end else if (in0_vld || in1_vld) begin
        m_ovf = 1'b1;
      end
    end
    #1;
    chk("count",       64'(count),       64'(mq.size()));
    chk("in_ready",    64'(in_ready),    64'(mq.size() <= DEPTH - 2));
    chk("overflow",    64'(overflow),    64'(m_ovf));
    chk("mem_load",    64'(mem_load),    64'(m_busy && !m_cur.store));
    chk("mem_store",   64'(mem_store),   64'(m_busy && m_cur.store));
    chk("mem_addr",    64'(mem_addr),    64'(m_cur.addr));
    chk("mem_data",    64'(mem_data),    64'(m_cur.data));
    chk("ld_rsp_vld",  64'(ld_rsp_vld),  64'(m_rsp_vld));
    chk("ld_rsp_tag",  64'(ld_rsp_tag),  64'(m_rsp_tag));
    chk("ld_rsp_data", 64'(ld_rsp_data), 64'(m_rsp_data));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_lane0(input logic v, input logic st, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] t);
    in0_vld = v; in0_store = st; in0_addr = a; in0_data = d; in0_tag = t;
  endtask

  task automatic set_lane1(input logic v, input logic st, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] t);
    in1_vld = v; in1_store = st; in1_addr = a; in1_data = d; in1_tag = t;
  endtask

  task automatic pop_one();
    mem_done = 1'b1; mem_load_data = $urandom;
    tick();
    mem_done = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_count",    64'(count),      64'd0);
    chk("rst_in_ready", 64'(in_ready),   64'd1);
    chk("rst_flags",    64'({mem_load, mem_store, ld_rsp_vld, overflow}), 64'd0);

    // Single load: flags high two edges after push, response one cycle.
    set_lane0(1, 0, 32'h40, 32'h0, 5'd3);
    tick();
    set_lane0(0, 0, 0, 0, 0);
    chk("sl_count1",   64'(count),    64'd1);
    chk("sl_noflag",   64'(mem_load), 64'd0);
    tick();
    chk("sl_mem_load", 64'(mem_load), 64'd1);
    chk("sl_mem_addr", 64'(mem_addr), 64'h40);
    tick();
    mem_done = 1'b1; mem_load_data = 32'hDEADBEEF;
    tick();
    mem_done = 1'b0;
    chk("sl_rsp_vld",  64'(ld_rsp_vld),  64'd1);
    chk("sl_rsp_tag",  64'(ld_rsp_tag),  64'd3);
    chk("sl_rsp_data", 64'(ld_rsp_data), 64'hDEADBEEF);
    chk("sl_count0",   64'(count),       64'd0);
    chk("sl_flag_off", 64'(mem_load),    64'd0);
    tick();
    chk("sl_rsp_once", 64'(ld_rsp_vld),  64'd0);

    // Dual push: store then load, DONE gap between them.
    set_lane0(1, 1, 32'h10, 32'hAA, 5'd1);
    set_lane1(1, 0, 32'h14, 32'h0, 5'd7);
    tick();
    set_lane0(0, 0, 0, 0, 0); set_lane1(0, 0, 0, 0, 0);
    tick();
    chk("dp_store",    64'(mem_store), 64'd1);
    chk("dp_data",     64'(mem_data),  64'hAA);
    chk("dp_addr",     64'(mem_addr),  64'h10);
    mem_done = 1'b1; mem_load_data = 32'h1234;
    tick();
    mem_done = 1'b0;
    chk("dp_gap_flags", 64'({mem_load, mem_store}), 64'd0);
    chk("dp_no_rsp",    64'(ld_rsp_vld),            64'd0);
    chk("dp_count1",    64'(count),                 64'd1);
    tick();
    chk("dp_load",      64'(mem_load), 64'd1);
    chk("dp_load_addr", 64'(mem_addr), 64'h14);
    mem_done = 1'b1; mem_load_data = 32'h5678;
    tick();
    mem_done = 1'b0;
    chk("dp_rsp_vld",  64'(ld_rsp_vld),  64'd1);
    chk("dp_rsp_tag",  64'(ld_rsp_tag),  64'd7);
    chk("dp_rsp_data", 64'(ld_rsp_data), 64'h5678);
    tick();

    // Stray mem_done while idle.
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("stray_rsp",   64'(ld_rsp_vld), 64'd0);
    chk("stray_count", 64'(count),      64'd0);
    chk("stray_tag",   64'(ld_rsp_tag), 64'd7);

    // Fill with four dual pushes, then one more push to overflow.
    for (int i = 0; i < 5; i++) begin
      set_lane0(1, 0, 32'h100 + 32'(i * 8), 32'(i), 5'(10 + 2 * i));
      set_lane1(1, 0, 32'h104 + 32'(i * 8), 32'(i), 5'(11 + 2 * i));
      tick();
      if (i == 2) begin
        chk("fill_count6", 64'(count),    64'd6);
        chk("fill_ready6", 64'(in_ready), 64'd1);
      end
      if (i == 3) begin
        chk("fill_count8", 64'(count),    64'd8);
        chk("fill_ready8", 64'(in_ready), 64'd0);
        chk("fill_noovf",  64'(overflow), 64'd0);
      end
    end
    set_lane0(0, 0, 0, 0, 0); set_lane1(0, 0, 0, 0, 0);
    chk("ovf_set",   64'(overflow), 64'd1);
    chk("ovf_count", 64'(count),    64'd8);

    // Drain to three entries, then reset mid-BUSY.
    for (int i = 0; i < 5; i++) pop_one();
    chk("pre_rst_count", 64'(count),    64'd3);
    chk("pre_rst_busy",  64'(mem_load), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_outs", 64'({mem_load, mem_store, ld_rsp_vld, overflow}), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr),   64'd0);
    chk("mid_rst_tag",  64'(ld_rsp_tag), 64'd0);
    chk("mid_rst_cnt",  64'(count),      64'd0);
    chk("mid_rst_rdy",  64'(in_ready),   64'd1);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("post_rst_rsp", 64'(ld_rsp_vld), 64'd0);

    // Randomized traffic across many pointer wraps.
    for (int c = 0; c < 3000; c++) begin
      set_lane0($urandom_range(0, 9) < 4, $urandom_range(0, 1), $urandom, $urandom, 5'($urandom));
      set_lane1($urandom_range(0, 9) < 3, $urandom_range(0, 1), $urandom, $urandom, 5'($urandom));
      mem_done      = ($urandom_range(0, 9) < 4);
      mem_load_data = $urandom;
      rst           = ($urandom_range(0, 499) == 0);
      tick();
    end
    set_lane0(0, 0, 0, 0, 0); set_lane1(0, 0, 0, 0, 0);
    mem_done = 1'b0; rst = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
